// File: rtl/ro_sensor_aggregator.sv
// Windowed reduction engine for ring-oscillator sensor counts.
// Each snapshot is reduced one channel per cycle (SUM/MAX/MIN/SINGLE). The per-snapshot
// results are accumulated over 2^avg snapshots and the average is reported with the winning
// channel, a threshold alarm and a sticky saturation flag.
module ro_sensor_aggregator #(
  parameter int unsigned NUM_CH       = 16,
  parameter int unsigned IN_WIDTH     = 16,
  parameter int unsigned SUM_WIDTH    = 24,
  parameter int unsigned AVG_LOG2_MAX = 4,
  localparam int unsigned CH_W        = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [2:0]                   avg_log2,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [SUM_WIDTH-1:0]         thresh,
  input  logic                         in_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0]   in_data,
  output logic                         busy,
  output logic [SUM_WIDTH-1:0]         result,
  output logic [CH_W-1:0]              result_ch,
  output logic                         result_valid,
  output logic                         alarm,
  output logic                         overflow
);

  localparam int unsigned CNT_W = AVG_LOG2_MAX + 1;

  typedef enum logic [2:0] {StIdle, StWait, StScan, StAcc, StDone} state_e;
  typedef enum logic [1:0] {ModeSum, ModeMax, ModeMin, ModeSingle} mode_e;

  state_e                       state_q, state_d;
  mode_e                        mode_q, mode_d;
  logic [2:0]                   avg_q, avg_d;
  logic [NUM_CH-1:0]            mask_q, mask_d;
  logic [SUM_WIDTH-1:0]         thresh_q, thresh_d;
  logic [NUM_CH*IN_WIDTH-1:0]   snap_q, snap_d;
  logic [CH_W-1:0]              idx_q, idx_d;
  logic [SUM_WIDTH-1:0]         red_q, red_d;
  logic [CH_W-1:0]              ch_id_q, ch_id_d;
  logic                         seen_q, seen_d;
  logic [SUM_WIDTH-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0]         result_q, result_d;
  logic [CH_W-1:0]              result_ch_q, result_ch_d;
  logic                         result_valid_q, result_valid_d;
  logic                         alarm_q, alarm_d;
  logic                         overflow_q, overflow_d;

  logic [SUM_WIDTH-1:0]         ch_ext;
  logic [SUM_WIDTH:0]           red_sum;
  logic [SUM_WIDTH-1:0]         red_eff;
  logic [SUM_WIDTH:0]           acc_sum;
  logic [SUM_WIDTH-1:0]         acc_avg;
  logic [CNT_W-1:0]             win_len;

  assign ch_ext  = SUM_WIDTH'(snap_q[32'(idx_q) * IN_WIDTH +: IN_WIDTH]);
  assign red_sum = {1'b0, red_q} + {1'b0, ch_ext};
  // An empty mask leaves MIN at all-ones; report 0 instead.
  assign red_eff = seen_q ? red_q : '0;
  assign acc_sum = {1'b0, acc_q} + {1'b0, red_eff};
  assign acc_avg = acc_q >> avg_q;
  assign win_len = CNT_W'(1) << avg_q;

  // Next-state and datapath updates; every register holds unless its state updates it.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    avg_d          = avg_q;
    mask_d         = mask_q;
    thresh_d       = thresh_q;
    snap_d         = snap_q;
    idx_d          = idx_q;
    red_d          = red_q;
    ch_id_d        = ch_id_q;
    seen_d         = seen_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_ch_d    = result_ch_q;
    result_valid_d = 1'b0;
    alarm_d        = alarm_q;
    overflow_d     = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d     = mode_e'(mode);
          avg_d      = (32'(avg_log2) > AVG_LOG2_MAX) ? 3'(AVG_LOG2_MAX) : avg_log2;
          mask_d     = ch_mask;
          thresh_d   = thresh;
          acc_d      = '0;
          cnt_d      = '0;
          overflow_d = 1'b0;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (in_valid) begin
          snap_d  = in_data;
          idx_d   = '0;
          red_d   = (mode_q == ModeMin) ? '1 : '0;
          ch_id_d = '0;
          seen_d  = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (mask_q[idx_q]) begin
          seen_d = 1'b1;
          unique case (mode_q)
            ModeSum: begin
              if (red_sum[SUM_WIDTH]) begin
                red_d      = '1;
                overflow_d = 1'b1;
              end else begin
                red_d = red_sum[SUM_WIDTH-1:0];
              end
            end
            ModeMax: begin
              if (ch_ext > red_q) begin
                red_d   = ch_ext;
                ch_id_d = idx_q;
              end
            end
            ModeMin: begin
              if (ch_ext < red_q) begin
                red_d   = ch_ext;
                ch_id_d = idx_q;
              end
            end
            ModeSingle: begin
              if (!seen_q) begin
                red_d   = ch_ext;
                ch_id_d = idx_q;
              end
            end
            default: ;
          endcase
        end
        idx_d = idx_q + CH_W'(1);
        if (idx_q == CH_W'(NUM_CH - 1)) state_d = StAcc;
      end
      StAcc: begin
        if (acc_sum[SUM_WIDTH]) begin
          acc_d      = '1;
          overflow_d = 1'b1;
        end else begin
          acc_d = acc_sum[SUM_WIDTH-1:0];
        end
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ((cnt_q + CNT_W'(1)) == win_len) ? StDone : StWait;
      end
      StDone: begin
        result_d       = acc_avg;
        result_ch_d    = ch_id_q;
        alarm_d        = acc_avg > thresh_q;
        result_valid_d = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register: synchronous active-low reset, en low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      mode_q         <= ModeSum;
      avg_q          <= '0;
      mask_q         <= '0;
      thresh_q       <= '0;
      snap_q         <= '0;
      idx_q          <= '0;
      red_q          <= '0;
      ch_id_q        <= '0;
      seen_q         <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      alarm_q        <= 1'b0;
      overflow_q     <= 1'b0;
    end else if (en) begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      avg_q          <= avg_d;
      mask_q         <= mask_d;
      thresh_q       <= thresh_d;
      snap_q         <= snap_d;
      idx_q          <= idx_d;
      red_q          <= red_d;
      ch_id_q        <= ch_id_d;
      seen_q         <= seen_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_ch_q    <= result_ch_d;
      result_valid_q <= result_valid_d;
      alarm_q        <= alarm_d;
      overflow_q     <= overflow_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign alarm        = alarm_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ro_sensor_aggregator.sv
// Randomized self-checking bench for ro_sensor_aggregator against a window-level model.
module tb_ro_sensor_aggregator;

  localparam int unsigned NC   = 16;
  localparam int unsigned IW   = 16;
  localparam int unsigned SW   = 18;
  localparam int unsigned AM   = 4;
  localparam longint      MAXS = (64'd1 << SW) - 1;

  logic              clk = 1'b0;
  logic              rst, en, start, in_valid;
  logic [1:0]        mode;
  logic [2:0]        avg_log2;
  logic [NC-1:0]     ch_mask;
  logic [SW-1:0]     thresh;
  logic [NC*IW-1:0]  in_data;
  logic              busy, result_valid, alarm, overflow;
  logic [SW-1:0]     result;
  logic [3:0]        result_ch;

  int checks = 0;
  int errors = 0;

  logic [NC*IW-1:0]  snaps [16];

  ro_sensor_aggregator #(
    .NUM_CH      (NC),
    .IN_WIDTH    (IW),
    .SUM_WIDTH   (SW),
    .AVG_LOG2_MAX(AM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .mode        (mode),
    .avg_log2    (avg_log2),
    .ch_mask     (ch_mask),
    .thresh      (thresh),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .busy        (busy),
    .result      (result),
    .result_ch   (result_ch),
    .result_valid(result_valid),
    .alarm       (alarm),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*IW-1:0] rand_snap(input int kind);
    logic [NC*IW-1:0] d;
    for (int k = 0; k < NC; k++) begin
      case (kind)
        0:       d[k*IW +: IW] = IW'($urandom);
        1:       d[k*IW +: IW] = 16'hFFFF;
        default: d[k*IW +: IW] = IW'($urandom_range(0, 40));
      endcase
    end
    return d;
  endfunction

  // Per-snapshot reduction from the mode definitions (whole-array view).
  function automatic void reduce(input int md, input logic [NC-1:0] msk,
                                 input logic [NC*IW-1:0] s, output longint red,
                                 output int ch, output bit sat);
    longint v [NC];
    longint best;
    bit     any;
    red = 0; ch = 0; sat = 0; any = 0;
    for (int k = 0; k < NC; k++) v[k] = longint'(s[k*IW +: IW]);
    case (md)
      0: begin
        for (int k = 0; k < NC; k++) if (msk[k]) red += v[k];
        if (red > MAXS) begin red = MAXS; sat = 1; end
      end
      1: begin
        best = 0;
        for (int k = 0; k < NC; k++) if (msk[k] && v[k] > best) best = v[k];
        red = best;
        if (best > 0) begin
          for (int k = NC - 1; k >= 0; k--) if (msk[k] && v[k] == best) ch = k;
        end
      end
      2: begin
        best = MAXS;
        for (int k = 0; k < NC; k++) if (msk[k]) begin any = 1; if (v[k] < best) best = v[k]; end
        if (any) begin
          red = best;
          for (int k = NC - 1; k >= 0; k--) if (msk[k] && v[k] == best) ch = k;
        end
      end
      default: begin
        for (int k = NC - 1; k >= 0; k--) if (msk[k]) begin red = v[k]; ch = k; end
      end
    endcase
  endfunction

  // Runs one full window from snaps[], with optional junk start/in_valid and an en stall.
  task automatic run_window(input int md, input int avg, input logic [NC-1:0] msk,
                            input longint th, input bit stall, input bit junk);
    int     avg_c, n, budget, exp_ch, ch;
    longint acc, red, exp_res;
    bit     ovf, s;
    avg_c = (avg > int'(AM)) ? int'(AM) : avg;
    n = 1 << avg_c;
    acc = 0; ovf = 0; exp_ch = 0;
    for (int i = 0; i < n; i++) begin
      reduce(md, msk, snaps[i], red, ch, s);
      ovf |= s;
      acc += red;
      if (acc > MAXS) begin acc = MAXS; ovf = 1; end
      exp_ch = ch;
    end
    exp_res = acc >> avg_c;

    mode = 2'(md); avg_log2 = 3'(avg); ch_mask = msk; thresh = SW'(th); start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("ovf_cleared_by_start", overflow, 0);
    // Config inputs must not matter after the start edge.
    mode = 2'($urandom); avg_log2 = 3'($urandom); ch_mask = NC'($urandom);
    thresh = SW'($urandom);

    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        start = junk ? 1'($urandom) : 1'b0;
        tick();
      end
      in_valid = 1'b1; in_data = snaps[i]; start = 1'b0;
      tick();
      budget = (i == n - 1) ? 18 : 17;
      for (int c = 1; c <= budget; c++) begin
        if (stall && i == n - 1 && c == 4) begin
          en = 1'b0;
          repeat (5) begin
            in_valid = 1'($urandom); start = 1'($urandom); in_data = rand_snap(0);
            tick();
          end
          en = 1'b1;
        end
        in_valid = junk ? 1'($urandom) : 1'b0;
        in_data = rand_snap(0);
        start = junk ? 1'($urandom) : 1'b0;
        if (i == n - 1 && c == budget) check_eq("rv_not_early", result_valid, 0);
        tick();
      end
    end
    start = 1'b0; in_valid = 1'b0;
    check_eq("rv_pulse", result_valid, 1);
    check_eq("result", result, exp_res);
    check_eq("result_ch", result_ch, exp_ch);
    check_eq("alarm", alarm, exp_res > th);
    check_eq("overflow", overflow, ovf);
    check_eq("busy_idle", busy, 0);
    tick();
    check_eq("rv_one_cycle", result_valid, 0);
    check_eq("result_hold", result, exp_res);
  endtask

  initial begin
    int md, avg, kind, sel;
    logic [NC-1:0] msk;
    rst = 1'b0; en = 1'b1; start = 1'b0; in_valid = 1'b0; mode = '0; avg_log2 = '0;
    ch_mask = '0; thresh = '0; in_data = '0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_result_ch", result_ch, 0);
    check_eq("rst_rv", result_valid, 0);
    check_eq("rst_alarm", alarm, 0);
    check_eq("rst_overflow", overflow, 0);
    rst = 1'b1;
    tick();

    // SUM, ch k = k+1
    for (int k = 0; k < NC; k++) snaps[0][k*IW +: IW] = IW'(k + 1);
    run_window(0, 0, 16'hFFFF, 1000, 0, 1);
    check_eq("sum_136", result, 136);
    check_eq("sum_ch0", result_ch, 0);

    // MAX over ch 4..7, unmasked channels hold larger values
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NC; k++) snaps[i][k*IW +: IW] = (k >= 4 && k <= 7) ? 16'd10 : 16'd60000;
    end
    snaps[0][5*IW +: IW] = 16'd100;
    snaps[1][5*IW +: IW] = 16'd200;
    snaps[2][5*IW +: IW] = 16'd300;
    snaps[3][7*IW +: IW] = 16'd400;
    run_window(1, 2, 16'h00F0, 0, 0, 1);
    check_eq("max_250", result, 250);
    check_eq("max_ch7", result_ch, 7);

    // MIN with tie on ch 3 and 9
    for (int k = 0; k < NC; k++) snaps[0][k*IW +: IW] = (k == 3 || k == 9) ? 16'd5 : 16'd50;
    run_window(2, 0, 16'hFFFF, 0, 0, 1);
    check_eq("min_5", result, 5);
    check_eq("min_ch3", result_ch, 3);
    run_window(2, 0, 16'h0000, 0, 0, 1);
    check_eq("min_empty", result, 0);

    // Saturation
    snaps[0] = {NC{16'hFFFF}};
    run_window(0, 0, 16'hFFFF, 0, 0, 1);
    check_eq("sat_result", result, MAXS);
    check_eq("sat_overflow", overflow, 1);

    // en low for 5 cycles mid-SCAN (latency +5 checked inside)
    for (int k = 0; k < NC; k++) snaps[0][k*IW +: IW] = IW'(k + 1);
    run_window(0, 0, 16'hFFFF, 1, 1, 1);

    // en low ignores start in IDLE
    en = 1'b0; start = 1'b1;
    tick();
    check_eq("en_low_start_ignored", busy, 0);
    check_eq("en_low_rv_frozen", result_valid, 0);
    en = 1'b1; start = 1'b0;

    // Reset after 2 of 4 snapshots
    mode = 2'd0; avg_log2 = 3'd2; ch_mask = 16'hFFFF; thresh = '0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = {NC{16'h8000}};
      tick();
      in_valid = 1'b0;
      repeat ((i < 2) ? 17 : 5) tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_alarm", alarm, 0);
    check_eq("midrst_rv", result_valid, 0);
    check_eq("midrst_overflow", overflow, 0);

    // Alarm boundary, also a clean window after reset
    snaps[0] = '0;
    snaps[0][0 +: IW] = 16'd100;
    run_window(0, 0, 16'h0001, 99, 0, 1);
    check_eq("alarm_99", alarm, 1);
    check_eq("post_rst_result", result, 100);
    run_window(0, 0, 16'h0001, 100, 0, 1);
    check_eq("alarm_100", alarm, 0);

    // Randomized windows
    for (int w = 0; w < 30; w++) begin
      md   = $urandom_range(0, 3);
      avg  = $urandom_range(0, 6);
      sel  = $urandom_range(0, 5);
      msk  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : NC'($urandom);
      kind = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) snaps[i] = rand_snap(kind);
      run_window(md, avg, msk, longint'($urandom_range(0, int'(MAXS))),
                 ($urandom_range(0, 4) == 0), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
